// File: rtl/mem_stage.sv
// Pipeline MEM stage: issues one load/store per instruction on a req/ack bus,
// aligns store data, extracts load data and registers the MEM/WB result.
module mem_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        in_flag,
   input  logic [31:0] in_pc4,
   input  logic [31:0] in_ext,
   input  logic [31:0] in_ALU_C,
   input  logic [31:0] in_rd,
   input  logic [4:0]  in_wR,
   input  logic [1:0]  in_rf_we,
   input  logic [1:0]  in_rf_wsel,
   input  logic [1:0]  in_ram_we,
   input  logic [2:0]  in_ram_rsel,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        stall,
   output logic        wb_valid,
   output logic        wb_rf_we,
   output logic [4:0]  wb_wR,
   output logic [31:0] wb_wD,
   output logic        misalign,
   output logic        dbg_busy
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t      state;
   logic        is_store, is_load, mem_op, misaligned_op;
   logic [1:0]  acc_size;
   logic [3:0]  st_strb;
   logic [31:0] st_data, wd_sel, ld_shift, ld_data;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   logic [2:0]  ld_rsel;
   logic [1:0]  ld_off;
   logic [4:0]  lat_wR;
   logic        lat_rf_we, lat_use_load, kill;
   logic [31:0] lat_wd;

   assign is_store = |in_ram_we;
   assign is_load  = (in_ram_rsel >= 3'd1) && (in_ram_rsel <= 3'd5);
   assign mem_op   = is_store | is_load;
   assign dbg_busy = (state == BUSY);

   // acc_size: 0 = byte, 1 = half, 2 = word; a store wins over a load
   always_comb begin
      acc_size = 2'd2;
      if (is_store) begin
         case (in_ram_we)
            2'b01:   acc_size = 2'd0;
            2'b10:   acc_size = 2'd1;
            default: acc_size = 2'd2;
         endcase
      end else begin
         case (in_ram_rsel)
            3'd1, 3'd2: acc_size = 2'd0;
            3'd3, 3'd4: acc_size = 2'd1;
            default:    acc_size = 2'd2;
         endcase
      end
   end

   assign misaligned_op = mem_op & (((acc_size == 2'd1) & in_ALU_C[0]) |
                                    ((acc_size == 2'd2) & (|in_ALU_C[1:0])));

   // Misaligned ops retire in one cycle without a bus access, so they never stall.
   assign stall = in_flag & mem_op & ~misaligned_op & ~((state == BUSY) & mem_ack);

   always_comb begin
      st_strb = 4'b1111;
      st_data = in_rd;
      case (acc_size)
         2'd0: begin
            st_strb = 4'b0001 << in_ALU_C[1:0];
            st_data = {4{in_rd[7:0]}};
         end
         2'd1: begin
            st_strb = 4'b0011 << in_ALU_C[1:0];
            st_data = {2{in_rd[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      wd_sel = in_ALU_C;
      case (in_rf_wsel)
         2'b00:   wd_sel = in_ALU_C;
         2'b01:   wd_sel = 32'd0;
         2'b10:   wd_sel = in_pc4;
         default: wd_sel = in_ext;
      endcase
   end

   assign ld_shift = mem_rdata >> {ld_off, 3'b000};
   assign ld_byte  = ld_shift[7:0];
   assign ld_half  = ld_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

   always_comb begin
      ld_data = mem_rdata;
      case (ld_rsel)
         3'd1:    ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'd2:    ld_data = {24'd0, ld_byte};
         3'd3:    ld_data = {{16{ld_half[15]}}, ld_half};
         3'd4:    ld_data = {16'd0, ld_half};
         default: ld_data = mem_rdata;
      endcase
   end

   // Bus handshake: mem_req rises with addr/wdata/wstrb/we and all of them hold
   // until the cycle mem_ack=1; that edge completes the transfer and drops mem_req.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= 32'd0;
         mem_wdata    <= 32'd0;
         mem_wstrb    <= 4'd0;
         misalign     <= 1'b0;
         wb_valid     <= 1'b0;
         wb_rf_we     <= 1'b0;
         wb_wR        <= 5'd0;
         wb_wD        <= 32'd0;
         ld_rsel      <= 3'd0;
         ld_off       <= 2'd0;
         lat_wR       <= 5'd0;
         lat_rf_we    <= 1'b0;
         lat_use_load <= 1'b0;
         lat_wd       <= 32'd0;
         kill         <= 1'b0;
      end else begin
         misalign <= 1'b0;
         wb_valid <= 1'b0;
         wb_rf_we <= 1'b0;
         case (state)
            IDLE: begin
               if (in_flag && !flush) begin
                  if (misaligned_op) begin
                     misalign <= 1'b1;
                     wb_valid <= 1'b1;
                     wb_wR    <= in_wR;
                     wb_wD    <= 32'd0;
                  end else if (mem_op) begin
                     state        <= BUSY;
                     mem_req      <= 1'b1;
                     mem_we       <= is_store;
                     mem_addr     <= {in_ALU_C[31:2], 2'b00};
                     mem_wdata    <= is_store ? st_data : 32'd0;
                     mem_wstrb    <= is_store ? st_strb : 4'd0;
                     ld_rsel      <= is_store ? 3'd0 : in_ram_rsel;
                     ld_off       <= in_ALU_C[1:0];
                     lat_wR       <= in_wR;
                     lat_rf_we    <= |in_rf_we;
                     lat_use_load <= ~is_store & (in_rf_wsel == 2'b01);
                     lat_wd       <= wd_sel;
                     kill         <= 1'b0;
                  end else begin
                     wb_valid <= 1'b1;
                     wb_rf_we <= |in_rf_we;
                     wb_wR    <= in_wR;
                     wb_wD    <= wd_sel;
                  end
               end
            end
            BUSY: begin
               if (flush) kill <= 1'b1;
               if (mem_ack) begin
                  state     <= IDLE;
                  mem_req   <= 1'b0;
                  mem_we    <= 1'b0;
                  mem_wstrb <= 4'd0;
                  wb_valid  <= ~(kill | flush);
                  wb_rf_we  <= ~(kill | flush) & lat_rf_we;
                  wb_wR     <= lat_wR;
                  wb_wD     <= lat_use_load ? ld_data : lat_wd;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU write-back, loads, stores, misalign,
// flush and reset cases against hand-computed values.
module tb_mem_stage;

   logic        clk, rst, flush, in_flag;
   logic [31:0] in_pc4, in_ext, in_ALU_C, in_rd;
   logic [4:0]  in_wR;
   logic [1:0]  in_rf_we, in_rf_wsel, in_ram_we;
   logic [2:0]  in_ram_rsel;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;
   logic        stall, wb_valid, wb_rf_we, misalign, dbg_busy;
   logic [4:0]  wb_wR;
   logic [31:0] wb_wD;

   int n_checks = 0;
   int n_fail   = 0;
   int stall_cnt;
   logic [31:0] exp_q[$];

   mem_stage dut (
      .clk(clk), .rst(rst), .flush(flush), .in_flag(in_flag),
      .in_pc4(in_pc4), .in_ext(in_ext), .in_ALU_C(in_ALU_C), .in_rd(in_rd),
      .in_wR(in_wR), .in_rf_we(in_rf_we), .in_rf_wsel(in_rf_wsel),
      .in_ram_we(in_ram_we), .in_ram_rsel(in_ram_rsel),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .stall(stall), .wb_valid(wb_valid),
      .wb_rf_we(wb_rf_we), .wb_wR(wb_wR), .wb_wD(wb_wD),
      .misalign(misalign), .dbg_busy(dbg_busy)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      in_flag = 1'b0; flush = 1'b0; in_pc4 = 32'd0; in_ext = 32'd0;
      in_ALU_C = 32'd0; in_rd = 32'd0; in_wR = 5'd0; in_rf_we = 2'd0;
      in_rf_wsel = 2'd0; in_ram_we = 2'd0; in_ram_rsel = 3'd0;
      mem_ack = 1'b0; mem_rdata = 32'd0;
   endtask

   task automatic set_op(input logic [31:0] alu, input logic [31:0] rd, input logic [4:0] wr,
                         input logic [1:0] rf_we, input logic [1:0] wsel,
                         input logic [1:0] ram_we, input logic [2:0] rsel);
      in_flag = 1'b1; in_ALU_C = alu; in_rd = rd; in_wR = wr; in_rf_we = rf_we;
      in_rf_wsel = wsel; in_ram_we = ram_we; in_ram_rsel = rsel;
   endtask

   // Presented op is an aligned memory op in IDLE; ack comes after busy_n BUSY cycles.
   task automatic mem_txn(input int busy_n, input logic [31:0] rdata, input logic do_flush,
                          input logic [31:0] e_addr, input logic e_we,
                          input logic [3:0] e_strb, input logic [31:0] e_wdata,
                          output int scnt);
      scnt = 0;
      #1;
      if (stall) scnt++;
      tick();
      for (int i = 0; i < busy_n; i++) begin
         check("req_held", 32'(mem_req), 32'd1);
         check("addr_held", mem_addr, e_addr);
         check("we_held", 32'(mem_we), 32'(e_we));
         check("strb_held", 32'(mem_wstrb), 32'(e_strb));
         check("wdata_held", mem_wdata, e_wdata);
         if (stall) scnt++;
         flush = (do_flush && i == 0);
         tick();
      end
      flush = 1'b0;
      mem_ack = 1'b1;
      mem_rdata = rdata;
      #1;
      check("stall_ack", 32'(stall), 32'd0);
      tick();
      mem_ack = 1'b0;
      check("req_drop", 32'(mem_req), 32'd0);
      check("idle_after", 32'(dbg_busy), 32'd0);
   endtask

   // scoreboard: every register-file write must match the next queued value
   always @(negedge clk) begin
      if (rst && wb_valid && wb_rf_we) begin
         if (exp_q.size() == 0) check("wb_unexpected", 32'(wb_wD), 32'hxxxx_xxxx);
         else check("wb_data", wb_wD, exp_q.pop_front());
      end
   end

   initial begin
      clear_in();
      rst = 1'b0;
      tick(); tick();
      check("rst_req", 32'(mem_req), 32'd0);
      check("rst_valid", 32'(wb_valid), 32'd0);
      check("rst_addr", mem_addr, 32'd0);
      check("rst_wd", wb_wD, 32'd0);
      check("rst_busy", 32'(dbg_busy), 32'd0);
      rst = 1'b1;
      tick();

      // ALU op
      set_op(32'h1234, 32'd0, 5'd5, 2'd1, 2'b00, 2'b00, 3'd0);
      exp_q.push_back(32'h1234);
      #1 check("alu_stall", 32'(stall), 32'd0);
      tick();
      check("alu_valid", 32'(wb_valid), 32'd1);
      check("alu_wd", wb_wD, 32'h1234);
      check("alu_wr", 32'(wb_wR), 32'd5);
      check("alu_we", 32'(wb_rf_we), 32'd1);

      // pc4 and ext selects
      set_op(32'h9, 32'd0, 5'd7, 2'd1, 2'b10, 2'b00, 3'd0);
      in_pc4 = 32'h44;
      exp_q.push_back(32'h44);
      tick();
      check("pc4_wr", 32'(wb_wR), 32'd7);
      set_op(32'h9, 32'd0, 5'd8, 2'd2, 2'b11, 2'b00, 3'd0);
      in_ext = 32'hFFFF_FFF0;
      exp_q.push_back(32'hFFFF_FFF0);
      tick();
      check("ext_valid", 32'(wb_valid), 32'd1);
      clear_in();

      // lb at 0x103, ack after 3 BUSY cycles
      set_op(32'h103, 32'd0, 5'd9, 2'd1, 2'b01, 2'b00, 3'd1);
      exp_q.push_back(32'hFFFF_FF80);
      mem_txn(3, 32'h80FF_0000, 1'b0, 32'h100, 1'b0, 4'b0000, 32'd0, stall_cnt);
      check("lb_stall_cycles", 32'(stall_cnt), 32'd4);
      check("lb_valid", 32'(wb_valid), 32'd1);
      check("lb_wd", wb_wD, 32'hFFFF_FF80);
      check("lb_wr", 32'(wb_wR), 32'd9);
      clear_in();

      // lbu, lh, lw
      set_op(32'h101, 32'd0, 5'd10, 2'd1, 2'b01, 2'b00, 3'd2);
      exp_q.push_back(32'h0000_00C3);
      mem_txn(1, 32'h0000_C300, 1'b0, 32'h100, 1'b0, 4'b0000, 32'd0, stall_cnt);
      set_op(32'h102, 32'd0, 5'd11, 2'd1, 2'b01, 2'b00, 3'd3);
      exp_q.push_back(32'hFFFF_8001);
      mem_txn(0, 32'h8001_1234, 1'b0, 32'h100, 1'b0, 4'b0000, 32'd0, stall_cnt);
      check("lh_min_latency_stall", 32'(stall_cnt), 32'd1);
      set_op(32'h300, 32'd0, 5'd12, 2'd1, 2'b01, 2'b00, 3'd5);
      exp_q.push_back(32'hDEAD_BEEF);
      mem_txn(2, 32'hDEAD_BEEF, 1'b0, 32'h300, 1'b0, 4'b0000, 32'd0, stall_cnt);
      clear_in();

      // stores
      set_op(32'h202, 32'h0000_ABCD, 5'd0, 2'd0, 2'b00, 2'b10, 3'd0);
      mem_txn(1, 32'd0, 1'b0, 32'h200, 1'b1, 4'b1100, 32'hABCD_ABCD, stall_cnt);
      check("sh_valid", 32'(wb_valid), 32'd1);
      check("sh_rf_we", 32'(wb_rf_we), 32'd0);
      set_op(32'h101, 32'h0000_005A, 5'd0, 2'd0, 2'b00, 2'b01, 3'd5);
      mem_txn(1, 32'd0, 1'b0, 32'h100, 1'b1, 4'b0010, 32'h5A5A_5A5A, stall_cnt);
      set_op(32'h404, 32'h1357_9BDF, 5'd0, 2'd0, 2'b00, 2'b11, 3'd0);
      mem_txn(1, 32'd0, 1'b0, 32'h404, 1'b1, 4'b1111, 32'h1357_9BDF, stall_cnt);
      clear_in();

      // misaligned lw and lh
      set_op(32'h301, 32'd0, 5'd4, 2'd1, 2'b01, 2'b00, 3'd5);
      #1 check("mis_stall", 32'(stall), 32'd0);
      tick();
      check("mis_pulse", 32'(misalign), 32'd1);
      check("mis_valid", 32'(wb_valid), 32'd1);
      check("mis_rf_we", 32'(wb_rf_we), 32'd0);
      check("mis_noreq", 32'(mem_req), 32'd0);
      set_op(32'h105, 32'd0, 5'd4, 2'd1, 2'b01, 2'b00, 3'd4);
      tick();
      check("mis_h_pulse", 32'(misalign), 32'd1);
      check("mis_h_noreq", 32'(mem_req), 32'd0);
      clear_in();
      tick();
      check("mis_one_cycle", 32'(misalign), 32'd0);

      // lhu flushed while BUSY, ack two cycles later
      set_op(32'h206, 32'd0, 5'd3, 2'd1, 2'b01, 2'b00, 3'd4);
      mem_txn(2, 32'h1111_2222, 1'b1, 32'h204, 1'b0, 4'b0000, 32'd0, stall_cnt);
      check("flush_busy_valid", 32'(wb_valid), 32'd0);
      check("flush_busy_we", 32'(wb_rf_we), 32'd0);
      clear_in();

      // flush in IDLE and bubble
      set_op(32'h300, 32'd0, 5'd6, 2'd1, 2'b01, 2'b00, 3'd5);
      flush = 1'b1;
      tick();
      check("flush_idle_req", 32'(mem_req), 32'd0);
      check("flush_idle_valid", 32'(wb_valid), 32'd0);
      flush = 1'b0;
      set_op(32'h55, 32'd0, 5'd6, 2'd1, 2'b00, 2'b00, 3'd0);
      in_flag = 1'b0;
      tick();
      check("bubble_valid", 32'(wb_valid), 32'd0);
      check("bubble_we", 32'(wb_rf_we), 32'd0);

      // reset mid-BUSY, then late ack
      set_op(32'h500, 32'd0, 5'd2, 2'd1, 2'b01, 2'b00, 3'd5);
      tick();
      check("rbusy_req", 32'(mem_req), 32'd1);
      tick();
      rst = 1'b0;
      #1;
      check("rbusy_req_drop", 32'(mem_req), 32'd0);
      check("rbusy_state", 32'(dbg_busy), 32'd0);
      check("rbusy_addr", mem_addr, 32'd0);
      clear_in();
      tick();
      rst = 1'b1;
      mem_ack = 1'b1;
      mem_rdata = 32'hCAFE_F00D;
      tick();
      mem_ack = 1'b0;
      check("late_ack_valid", 32'(wb_valid), 32'd0);
      check("late_ack_req", 32'(mem_req), 32'd0);
      tick();

      check("wb_queue_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
